// File: rtl/serial_addsub_if.sv
// serial_addsub_if: bundles the request and result signals of serial_addsub.
//   master : drives start/sub/cin/a/b, observes busy/done/sum/cout/ovf
//   slave  : the adder side (inputs/outputs mirrored)
// The clock and reset are kept as plain ports on the modules.
interface serial_addsub_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;  // operation request
    logic             sub;    // 0 = a + b + cin, 1 = a - b - cin
    logic             cin;    // carry-in (add) / borrow-in (subtract)
    logic [WIDTH-1:0] a;      // operand A
    logic [WIDTH-1:0] b;      // operand B
    logic             busy;   // bits being processed
    logic             done;   // one-cycle completion pulse
    logic [WIDTH-1:0] sum;    // result, held until the next done
    logic             cout;   // carry out of the MSB (1 = no borrow on subtract)
    logic             ovf;    // signed overflow

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, LSB first.
// One full-adder bit (two half adders plus a carry flop) is evaluated per clock,
// so a WIDTH-bit result takes WIDTH cycles in RUN plus one DONE cycle.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high (priority over start)
//   bus  : serial_addsub_if.slave
//          start/sub/cin/a/b sampled in IDLE or DONE only
//          busy high during RUN, done high for the single DONE cycle
//          sum/cout/ovf updated only on entry to DONE
module serial_addsub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             half_s;
    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    always_comb begin
        // Two cascaded half adders; their carries OR into the majority.
        half_s   = a_sh_q[0] ^ b_sh_q[0];
        s_bit    = half_s ^ carry_q;
        c_next   = (a_sh_q[0] & b_sh_q[0]) | (half_s & carry_q);
        last_bit = (cnt_q == LastCnt);

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StRun: begin
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                res_d   = {s_bit, res_q[WIDTH-1:1]};
                carry_d = c_next;
                cnt_d   = cnt_q + CntW'(1);
                if (last_bit) begin
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    cout_d  = c_next;
                    // carry_q here is the carry into the MSB
                    ovf_d   = carry_q ^ c_next;
                    state_d = StDone;
                end
            end
            StIdle, StDone: begin
                state_d = StIdle;
                if (bus.start) begin
                    // Subtract as a + ~b + 1 - cin, so the borrow-in inverts the carry.
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.cin ^ bus.sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at WIDTH = 8, 16 and 2. One DUT per width shares clk/rst;
// cur_w selects which DUT receives start and whose outputs are observed.
module tb_serial_addsub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cur_w = 8;
    logic        drv_start = 1'b0;
    logic        drv_sub = 1'b0;
    logic        drv_cin = 1'b0;
    logic [63:0] drv_a = '0;
    logic [63:0] drv_b = '0;

    logic        obs_busy, obs_done, obs_cout, obs_ovf;
    logic [63:0] obs_sum;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [63:0] held_sum = '0;
    logic        held_co = 1'b0;
    logic        held_ov = 1'b0;

    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(8))  bus8 ();
    serial_addsub_if #(.WIDTH(16)) bus16 ();
    serial_addsub_if #(.WIDTH(2))  bus2 ();

    serial_addsub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_addsub #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    serial_addsub #(.WIDTH(2))  u_dut2  (.clk(clk), .rst(rst), .bus(bus2));

    assign bus8.start  = drv_start && (cur_w == 8);
    assign bus8.sub    = drv_sub;
    assign bus8.cin    = drv_cin;
    assign bus8.a      = drv_a[7:0];
    assign bus8.b      = drv_b[7:0];
    assign bus16.start = drv_start && (cur_w == 16);
    assign bus16.sub   = drv_sub;
    assign bus16.cin   = drv_cin;
    assign bus16.a     = drv_a[15:0];
    assign bus16.b     = drv_b[15:0];
    assign bus2.start  = drv_start && (cur_w == 2);
    assign bus2.sub    = drv_sub;
    assign bus2.cin    = drv_cin;
    assign bus2.a      = drv_a[1:0];
    assign bus2.b      = drv_b[1:0];

    always_comb begin
        obs_busy = bus8.busy;
        obs_done = bus8.done;
        obs_sum  = 64'(bus8.sum);
        obs_cout = bus8.cout;
        obs_ovf  = bus8.ovf;
        if (cur_w == 16) begin
            obs_busy = bus16.busy;
            obs_done = bus16.done;
            obs_sum  = 64'(bus16.sum);
            obs_cout = bus16.cout;
            obs_ovf  = bus16.ovf;
        end else if (cur_w == 2) begin
            obs_busy = bus2.busy;
            obs_done = bus2.done;
            obs_sum  = 64'(bus2.sum);
            obs_cout = bus2.cout;
            obs_ovf  = bus2.ovf;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (width %0d)", name, got, exp, cur_w);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input logic sub,
                         output logic [63:0] s, output logic co, output logic ov);
        longint ua, ub, sa, sb, t, r, lim, mask;
        mask = (longint'(1) << w) - 1;
        lim  = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        sa   = (ua >= lim) ? ua - (lim << 1) : ua;
        sb   = (ub >= lim) ? ub - (lim << 1) : ub;
        if (sub) begin
            t  = ua - ub - longint'(cin);
            co = (ua >= ub + longint'(cin));
            r  = sa - sb - longint'(cin);
        end else begin
            t  = ua + ub + longint'(cin);
            co = ((t >> w) & 1) != 0;
            r  = sa + sb + longint'(cin);
        end
        s  = 64'(t & mask);
        ov = (r > lim - 1) || (r < -lim);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drv_start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        held_sum = '0;
        held_co  = 1'b0;
        held_ov  = 1'b0;
    endtask

    // One operation with busy/done timing and output-hold checks. poke >= 0 raises
    // start with junk operands for one cycle mid-RUN; it must be ignored.
    task automatic op_check(input string name, input logic [63:0] a, input logic [63:0] b,
                            input logic cin, input logic sub, input logic [63:0] es,
                            input logic eco, input logic eov, input int poke);
        int bad;
        bad = 0;
        @(negedge clk);
        drv_a = a; drv_b = b; drv_cin = cin; drv_sub = sub; drv_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_start = 1'b0;
        for (int i = 0; i < cur_w; i++) begin
            if (i == poke) begin
                drv_start = 1'b1;
                drv_a = ~a; drv_b = a ^ b; drv_cin = ~cin; drv_sub = ~sub;
            end else if (i == poke + 1) begin
                drv_start = 1'b0;
            end
            if (obs_busy !== 1'b1 || obs_done !== 1'b0) bad++;
            if (obs_sum !== held_sum || obs_cout !== held_co || obs_ovf !== held_ov) bad++;
            @(negedge clk);
        end
        drv_start = 1'b0;
        check({name, " timing/hold"}, 64'(bad), 64'd0);
        check({name, " done"}, {63'd0, obs_done}, 64'd1);
        check({name, " busy_at_done"}, {63'd0, obs_busy}, 64'd0);
        check({name, " sum"}, obs_sum, es);
        check({name, " cout"}, {63'd0, obs_cout}, {63'd0, eco});
        check({name, " ovf"}, {63'd0, obs_ovf}, {63'd0, eov});
        held_sum = es; held_co = eco; held_ov = eov;
        @(negedge clk);
        check({name, " done_one_cycle"}, {62'd0, obs_done, obs_busy}, 64'd0);
    endtask

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    initial begin
        vec_t        vecs[7];
        logic [63:0] s1, s2, ra, rb, mask;
        logic        c1, c2, o1, o2, rc, rs;
        int          bad, ndone, poke;

        vecs[0] = '{64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1};
        vecs[1] = '{64'hFF, 64'h01, 1'b1, 1'b0, 64'h01, 1'b1, 1'b0};
        vecs[2] = '{64'h05, 64'h07, 1'b0, 1'b1, 64'hFE, 1'b0, 1'b0};
        vecs[3] = '{64'h80, 64'h01, 1'b0, 1'b1, 64'h7F, 1'b1, 1'b1};
        vecs[4] = '{64'h10, 64'h01, 1'b1, 1'b1, 64'h0E, 1'b1, 1'b0};
        vecs[5] = '{64'h80, 64'h80, 1'b0, 1'b0, 64'h00, 1'b1, 1'b1};
        vecs[6] = '{64'h00, 64'h00, 1'b1, 1'b1, 64'hFF, 1'b0, 1'b0};

        // Reset state of every instance.
        do_reset();
        foreach (vecs[k]) begin end
        for (int w = 0; w < 3; w++) begin
            cur_w = (w == 0) ? 8 : (w == 1) ? 16 : 2;
            #1;
            check("reset outputs", {obs_sum[59:0], obs_busy, obs_done, obs_cout, obs_ovf}, 64'd0);
        end
        cur_w = 8;

        // Directed table at WIDTH = 8.
        for (int k = 0; k < 7; k++) begin
            op_check($sformatf("vec%0d", k), vecs[k].a, vecs[k].b, vecs[k].cin, vecs[k].sub,
                     vecs[k].s, vecs[k].co, vecs[k].ov, -1);
        end

        // start pulsed mid-RUN: ignored, exactly one done.
        op_check("midrun_start", 64'h3C, 64'h15, 1'b0, 1'b0, 64'h51, 1'b0, 1'b0, 3);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (obs_done) ndone++;
        end
        check("midrun_single_done", 64'(ndone), 64'd0);

        // start held through DONE: back-to-back, sum held between the two done pulses.
        model(8, 64'h12, 64'h34, 1'b0, 1'b0, s1, c1, o1);
        model(8, 64'h40, 64'h41, 1'b1, 1'b1, s2, c2, o2);
        bad = 0;
        @(negedge clk);
        drv_a = 64'h12; drv_b = 64'h34; drv_cin = 1'b0; drv_sub = 1'b0; drv_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_a = 64'h40; drv_b = 64'h41; drv_cin = 1'b1; drv_sub = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (obs_busy !== 1'b1 || obs_done !== 1'b0 || obs_sum !== held_sum) bad++;
            @(negedge clk);
        end
        check("b2b first done", {63'd0, obs_done}, 64'd1);
        check("b2b first sum", obs_sum, s1);
        check("b2b first flags", {62'd0, obs_cout, obs_ovf}, {62'd0, c1, o1});
        @(negedge clk);
        drv_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (obs_busy !== 1'b1 || obs_done !== 1'b0 || obs_sum !== s1) bad++;
            @(negedge clk);
        end
        check("b2b timing/hold", 64'(bad), 64'd0);
        check("b2b second done", {63'd0, obs_done}, 64'd1);
        check("b2b second sum", obs_sum, s2);
        check("b2b second flags", {62'd0, obs_cout, obs_ovf}, {62'd0, c2, o2});
        held_sum = s2; held_co = c2; held_ov = o2;

        // Reset at bit 3 of a RUN, after a result with nonzero sum/cout.
        op_check("pre_reset", 64'hFF, 64'h01, 1'b1, 1'b0, 64'h01, 1'b1, 1'b0, -1);
        @(negedge clk);
        drv_a = 64'h7F; drv_b = 64'h01; drv_cin = 1'b0; drv_sub = 1'b0; drv_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        drv_start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_midrun outputs", {obs_sum[59:0], obs_busy, obs_done, obs_cout, obs_ovf},
              64'd0);
        rst = 1'b0;
        held_sum = '0; held_co = 1'b0; held_ov = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (obs_done || obs_busy) ndone++;
        end
        check("reset_midrun no done", 64'(ndone), 64'd0);
        op_check("post_reset", 64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, -1);

        // Random operations against the reference model at WIDTH 16 and 2.
        for (int w = 0; w < 2; w++) begin
            cur_w = (w == 0) ? 16 : 2;
            do_reset();
            mask = (64'd1 << cur_w) - 64'd1;
            for (int n = 0; n < 1000; n++) begin
                ra = {32'd0, $urandom} & mask;
                rb = {32'd0, $urandom} & mask;
                rc = 1'($urandom_range(0, 1));
                rs = 1'($urandom_range(0, 1));
                poke = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, cur_w - 2)) : -1;
                model(cur_w, ra, rb, rc, rs, s1, c1, o1);
                op_check($sformatf("rnd w%0d #%0d", cur_w, n), ra, rb, rc, rs, s1, c1, o1, poke);
                repeat ($urandom_range(0, 1)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
